uart_rx_sampler: RTL and testbench

UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

---
 rtl/uart_rx_sampler_if.sv | 24 ++
 rtl/uart_rx_sampler.sv | 103 ++++++++++
 tb/tb_uart_rx_sampler.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_sampler_if.sv
// Signal bundle between the RX FSM and the oversampling/majority-vote sampler.
interface uart_rx_sampler_if;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       cnt_en;
  logic       samp_en;
  logic [5:0] edge_count;
  logic [3:0] bit_count;
  logic       sampled_bit;
  logic       sample_valid;
  logic       frame_done;
  logic       prescale_err;

  modport master (
    output rx_in, prescale, par_en, cnt_en, samp_en,
    input  edge_count, bit_count, sampled_bit, sample_valid, frame_done, prescale_err
  );

  modport slave (
    input  rx_in, prescale, par_en, cnt_en, samp_en,
    output edge_count, bit_count, sampled_bit, sample_valid, frame_done, prescale_err
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// UART receive oversampler: edge/bit counters plus 3-point majority vote at mid-bit.
module uart_rx_sampler (
  input logic              clk,
  input logic              rst,
  uart_rx_sampler_if.slave bus
);
  logic       prescale_bad;
  logic [5:0] p_eff, p_last, samp_a, samp_b, samp_c;
  logic       wrap, last_bit;

  logic [5:0] edge_q, edge_d;
  logic [3:0] bit_q, bit_d;
  logic       len11_q, len11_d;
  logic       done_q, done_d;
  logic       err_q;
  logic       s0_q, s1_q, s2_q;
  logic       got0_q, got1_q;
  logic       sbit_q, valid_q;

  always_comb begin
    prescale_bad = !((bus.prescale == 6'd8) || (bus.prescale == 6'd16) ||
                     (bus.prescale == 6'd32));
    p_eff  = prescale_bad ? 6'd8 : bus.prescale;
    p_last = p_eff - 6'd1;
    samp_c = p_eff >> 1;
    samp_b = samp_c - 6'd1;
    samp_a = samp_c - 6'd2;
    // ">=" lets a mid-frame shrink of P wrap immediately
    wrap     = (edge_q >= p_last);
    last_bit = (bit_q == (len11_q ? 4'd11 : 4'd10));

    edge_d  = edge_q + 6'd1;
    bit_d   = bit_q;
    len11_d = len11_q;
    done_d  = 1'b0;
    if (!bus.cnt_en) begin
      edge_d  = '0;
      bit_d   = 4'd1;
      len11_d = bus.par_en;
    end else if (wrap) begin
      edge_d = '0;
      if (last_bit) begin
        bit_d   = 4'd1;
        len11_d = bus.par_en;
        done_d  = 1'b1;
      end else begin
        bit_d = bit_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      edge_q  <= '0;
      bit_q   <= '0;
      len11_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      got0_q  <= 1'b0;
      got1_q  <= 1'b0;
      sbit_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      len11_q <= len11_d;
      done_q  <= done_d;
      err_q   <= prescale_bad;
      valid_q <= 1'b0;
      // got flags chain so a vote needs all three samples from this bit
      if (!bus.cnt_en || wrap) begin
        got0_q <= 1'b0;
        got1_q <= 1'b0;
      end else if (bus.samp_en) begin
        if (edge_q == samp_a) begin
          s0_q   <= bus.rx_in;
          got0_q <= 1'b1;
        end
        if (edge_q == samp_b) begin
          s1_q   <= bus.rx_in;
          got1_q <= got0_q;
        end
        if (edge_q == samp_c) begin
          s2_q <= bus.rx_in;
          if (got0_q && got1_q) begin
            sbit_q  <= (s0_q & s1_q) | (s0_q & bus.rx_in) | (s1_q & bus.rx_in);
            valid_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.edge_count   = edge_q;
  assign bus.bit_count    = bit_q;
  assign bus.sampled_bit  = sbit_q;
  assign bus.sample_valid = valid_q;
  assign bus.frame_done   = done_q;
  assign bus.prescale_err = err_q;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: frames at P=8/16/32, glitch vote, errors, reset.
module tb_uart_rx_sampler;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   nvalid, ndone;
  int   done_t[$];
  logic exp_sbit = 1'b0;

  uart_rx_sampler_if bus_if ();
  uart_rx_sampler dut (.clk(clk), .rst(rst), .bus(bus_if));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drives one frame, bit b (0-based) held for p ticks; optional one-tick glitch.
  task automatic run_frame(input int p, input int nb, input logic [10:0] bits,
                           input int gbit, input int gedge);
    for (int b = 0; b < nb; b++) begin
      for (int e = 0; e < p; e++) begin
        bus_if.rx_in = (b == gbit && e == gedge) ? ~bits[b] : bits[b];
        tick();
        chk("edge", bus_if.edge_count, (e == p - 1) ? 0 : e + 1);
        chk("bit", bus_if.bit_count, (e == p - 1) ? ((b == nb - 1) ? 1 : b + 2) : b + 1);
        chk("done", bus_if.frame_done, (b == nb - 1 && e == p - 1) ? 1 : 0);
        if (e == p / 2) exp_sbit = bits[b];
        chk("valid", bus_if.sample_valid, (e == p / 2) ? 1 : 0);
        chk("sbit", bus_if.sampled_bit, exp_sbit);
        if (bus_if.sample_valid) nvalid++;
        if (bus_if.frame_done) begin
          ndone++;
          done_t.push_back(cyc);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_edge"}, bus_if.edge_count, 0);
    chk({tag, "_bit"}, bus_if.bit_count, 0);
    chk({tag, "_sbit"}, bus_if.sampled_bit, 0);
    chk({tag, "_valid"}, bus_if.sample_valid, 0);
    chk({tag, "_done"}, bus_if.frame_done, 0);
    chk({tag, "_err"}, bus_if.prescale_err, 0);
  endtask

  initial begin
    rst = 1'b0;
    bus_if.rx_in = 1'b1;
    bus_if.prescale = 6'd8;
    bus_if.par_en = 1'b0;
    bus_if.cnt_en = 1'b0;
    bus_if.samp_en = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");

    // release with cnt_en=0: bit_count reads 1 immediately
    rst = 1'b1;
    tick();
    chk("rel_bit", bus_if.bit_count, 1);
    chk("rel_edge", bus_if.edge_count, 0);

    // P=8 frame 0x5A, no parity
    bus_if.cnt_en = 1'b1;
    bus_if.samp_en = 1'b1;
    nvalid = 0;
    ndone = 0;
    run_frame(8, 10, {1'b0, 1'b1, 8'h5A, 1'b0}, -1, -1);
    chk("p8_nvalid", nvalid, 10);
    chk("p8_ndone", ndone, 1);

    // P=16 all ones with a single-tick glitch at edge 7 of bit 4
    bus_if.cnt_en = 1'b0;
    bus_if.prescale = 6'd16;
    tick();
    chk("p16_err", bus_if.prescale_err, 0);
    bus_if.cnt_en = 1'b1;
    nvalid = 0;
    run_frame(16, 10, 11'h7FF, 3, 7);
    chk("p16_nvalid", nvalid, 10);

    // P=32 with parity, two back-to-back frames
    bus_if.cnt_en = 1'b0;
    bus_if.prescale = 6'd32;
    bus_if.par_en = 1'b1;
    tick();
    bus_if.cnt_en = 1'b1;
    ndone = 0;
    done_t.delete();
    run_frame(32, 11, {1'b1, 1'b0, 8'hC3, 1'b0}, -1, -1);
    run_frame(32, 11, {1'b1, 1'b1, 8'h35, 1'b0}, -1, -1);
    chk("p32_ndone", ndone, 2);
    if (done_t.size() == 2) chk("p32_gap", done_t[1] - done_t[0], 352);
    else chk("p32_gap_count", done_t.size(), 2);

    // illegal prescale falls back to P=8
    bus_if.cnt_en = 1'b0;
    bus_if.par_en = 1'b0;
    bus_if.samp_en = 1'b0;
    bus_if.prescale = 6'd12;
    tick();
    chk("bad_err", bus_if.prescale_err, 1);
    bus_if.cnt_en = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      chk("bad_edge", bus_if.edge_count, (e == 7) ? 0 : e + 1);
      chk("bad_valid", bus_if.sample_valid, 0);
    end
    chk("bad_bit", bus_if.bit_count, 2);
    bus_if.prescale = 6'd16;
    tick();
    chk("good_err", bus_if.prescale_err, 0);

    // samp_en dropped at edge 3 of the second bit
    bus_if.cnt_en = 1'b0;
    bus_if.prescale = 6'd8;
    bus_if.samp_en = 1'b1;
    tick();
    bus_if.cnt_en = 1'b1;
    bus_if.rx_in = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      chk("se_b1_valid", bus_if.sample_valid, (e == 4) ? 1 : 0);
    end
    chk("se_b1_sbit", bus_if.sampled_bit, 0);
    bus_if.rx_in = 1'b1;
    for (int e = 0; e < 8; e++) begin
      bus_if.samp_en = (e != 3);
      tick();
      chk("se_b2_valid", bus_if.sample_valid, 0);
      chk("se_b2_sbit", bus_if.sampled_bit, 0);
    end
    bus_if.samp_en = 1'b1;

    // reset mid-frame at bit_count=5
    bus_if.cnt_en = 1'b0;
    tick();
    bus_if.cnt_en = 1'b1;
    for (int i = 0; i < 35; i++) tick();
    chk("mid_bit", bus_if.bit_count, 5);
    chk("mid_edge", bus_if.edge_count, 3);
    rst = 1'b0;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b1;
    bus_if.cnt_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("post_bit", bus_if.bit_count, 1);
      chk("post_edge", bus_if.edge_count, 0);
      chk("post_valid", bus_if.sample_valid, 0);
      chk("post_done", bus_if.frame_done, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
